ho_uart_frame_sequencer: RTL and testbench

Parametrised UART framing sequencer for the hardware-obfuscation core. It assembles a byte stream from the UART receiver into a packed load bus and pulses the core start. It captures the core result and streams it back byte-by-byte through the UART transmitter. Compared with the fixed-field loader it adds:
- configurable frame sizes;
- an inter-byte timeout;
- prefix (key) retention across frames;
- continuous re-arming without reset.

---
 rtl/ho_uart_frame_sequencer.sv | 144 ++++++++++++++
 tb/tb_ho_uart_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ho_uart_frame_sequencer.sv
// ho_uart_frame_sequencer: assembles received UART bytes into a core load bus, starts the core, streams its result back
//
// Ports:
//   CLK, RSTn                          clock; synchronous active-low reset
//   en, rx_valid, rx_data              receiver byte strobe/data, gated by en while loading
//   keep_prefix                        sampled on the first byte of a frame: retain the previous prefix bytes
//   load_bus, core_start               assembled frame (first byte in the MSBs) and one-cycle core start
//   core_done, core_result             core result strobe and data
//   tx_start, tx_data, tx_busy         UART transmitter handshake
//   busy                               high whenever not loading
//   done, timeout_err, rx_drop         one-cycle status pulses
module ho_uart_frame_sequencer #(
    parameter int IN_BYTES       = 66,
    parameter int OUT_BYTES      = 16,
    parameter int PREFIX_BYTES   = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   en,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   keep_prefix,
    output logic [8*IN_BYTES-1:0]  load_bus,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [8*OUT_BYTES-1:0] core_result,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic                   rx_drop
);
    localparam int LW = 8 * IN_BYTES;
    localparam int OW = 8 * OUT_BYTES;
    localparam int CW = $clog2((IN_BYTES > OUT_BYTES ? IN_BYTES : OUT_BYTES) + 1);
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Bits that shift when the prefix is retained; the prefix bytes above them stay put.
    localparam logic [LW-1:0] LOW_MASK = ~({LW{1'b1}} << (8 * (IN_BYTES - PREFIX_BYTES)));

    typedef enum logic [2:0] {LOAD, START, WAIT, TX_SEND, TX_ACK, TX_DRAIN, FIN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [TW-1:0] timer, timer_n;
    logic          keep_q, keep_n, keep_now, prefix_valid, prefix_valid_n;
    logic          tx_start_n, timeout_n, sent_last;
    logic [7:0]    tx_data_n;
    logic [LW-1:0] load_bus_n, shifted;
    logic [OW-1:0] shift, shift_n, src;

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        timer_n        = '0;
        keep_n         = keep_q;
        prefix_valid_n = prefix_valid;
        load_bus_n     = load_bus;
        shift_n        = shift;
        tx_start_n     = tx_start;
        tx_data_n      = tx_data;
        timeout_n      = 1'b0;
        // A zero count marks frame start (after one byte the count is always at least 1),
        // so the prefix decision is made there and latched for the rest of the frame.
        keep_now       = (cnt == '0) ? keep_prefix && prefix_valid : keep_q;
        cnt_inc        = ((cnt == '0 && keep_now) ? CW'(PREFIX_BYTES) : cnt) + CW'(1);
        shifted        = {load_bus[LW-9:0], rx_data};
        sent_last      = cnt + CW'(1) == CW'(OUT_BYTES);
        src            = (state == WAIT) ? core_result : shift;
        case (state)
            LOAD: if (rx_valid && en) begin
                keep_n     = keep_now;
                load_bus_n = keep_now ? (load_bus & ~LOW_MASK) | (shifted & LOW_MASK) : shifted;
                state_n    = (cnt_inc == CW'(IN_BYTES)) ? START : LOAD;
                cnt_n      = (cnt_inc == CW'(IN_BYTES)) ? '0 : cnt_inc;
            end else if (TIMEOUT_CYCLES > 0 && cnt != '0) begin
                timeout_n = timer == TW'(TIMEOUT_CYCLES - 1);
                timer_n   = timeout_n ? '0 : timer + TW'(1);
                cnt_n     = timeout_n ? '0 : cnt;
            end
            START: state_n = WAIT;
            WAIT: if (core_done) begin
                shift_n = core_result;
                state_n = TX_SEND;
            end
            TX_ACK: if (tx_busy) begin
                tx_start_n = 1'b0;
                cnt_n      = sent_last ? '0 : cnt + CW'(1);
                state_n    = sent_last ? TX_DRAIN : TX_SEND;
            end
            TX_DRAIN: if (!tx_busy) state_n = FIN;
            FIN: begin
                state_n        = LOAD;
                prefix_valid_n = 1'b1;
                cnt_n          = '0;
            end
            default: ;
        endcase
        // Launch a byte straight from WAIT when the transmitter is idle so the first
        // tx_start follows core_done by one cycle with a registered output.
        if (((state == WAIT && core_done) || state == TX_SEND) && !tx_busy) begin
            tx_start_n = 1'b1;
            tx_data_n  = src[OW-1 -: 8];
            shift_n    = (src << 8) | (src >> (OW - 8));
            state_n    = TX_ACK;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state        <= LOAD;
            cnt          <= '0;
            timer        <= '0;
            keep_q       <= 1'b0;
            prefix_valid <= 1'b0;
            shift        <= '0;
            load_bus     <= '0;
            core_start   <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            rx_drop      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            timer        <= timer_n;
            keep_q       <= keep_n;
            prefix_valid <= prefix_valid_n;
            shift        <= shift_n;
            load_bus     <= load_bus_n;
            core_start   <= state_n == START;
            tx_start     <= tx_start_n;
            tx_data      <= tx_data_n;
            busy         <= state_n != LOAD;
            done         <= state_n == FIN;
            timeout_err  <= timeout_n;
            rx_drop      <= rx_valid && state != LOAD;
        end
    end
endmodule

// File: tb/tb_ho_uart_frame_sequencer.sv
// tb_ho_uart_frame_sequencer: scoreboard bench with a byte-queue reference model, core and transmitter responders
module tb_ho_uart_frame_sequencer;
    localparam int IN_BYTES = 4, OUT_BYTES = 2, PREFIX_BYTES = 2, TIMEOUT_CYCLES = 100;
    localparam int TX_BUSY_CYCLES = 20, CORE_DELAY = 5;

    logic        CLK = 0, RSTn = 0, en = 0, rx_valid = 0, keep_prefix = 0, core_done = 0, tx_busy = 0;
    logic [7:0]  rx_data = 0;
    logic [15:0] core_result = 0;
    logic [31:0] load_bus;
    logic [7:0]  tx_data;
    logic        core_start, tx_start, busy, done, timeout_err, rx_drop;

    ho_uart_frame_sequencer #(
        .IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES), .PREFIX_BYTES(PREFIX_BYTES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .en(en), .rx_valid(rx_valid), .rx_data(rx_data), .keep_prefix(keep_prefix),
        .load_bus(load_bus), .core_start(core_start), .core_done(core_done), .core_result(core_result),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy), .done(done),
        .timeout_err(timeout_err), .rx_drop(rx_drop)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0, errors = 0, done_cnt = 0;

    typedef struct { logic [31:0] bus; int cyc; } frame_t;
    typedef struct { logic [7:0] data; int cyc; bit last; } txb_t;
    frame_t exp_frame[$];
    txb_t   exp_tx[$];
    int     exp_done[$], exp_to[$], exp_drop[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    frame_t mf;
    always @(negedge CLK) begin
        if (core_start) begin
            if (exp_frame.size() == 0) check("core_start_unexpected", core_start, 0);
            else begin
                mf = exp_frame.pop_front();
                check("load_bus", load_bus, mf.bus);
                check("core_start_cycle", cyc, mf.cyc);
            end
        end
        if (done) begin
            done_cnt++;
            if (exp_done.size() == 0) check("done_unexpected", done, 0);
            else check("done_cycle", cyc, exp_done.pop_front());
        end
        if (timeout_err) begin
            if (exp_to.size() == 0) check("timeout_unexpected", timeout_err, 0);
            else check("timeout_cycle", cyc, exp_to.pop_front());
        end
        if (rx_drop) begin
            if (exp_drop.size() == 0) check("rx_drop_unexpected", rx_drop, 0);
            else check("rx_drop_cycle", cyc, exp_drop.pop_front());
        end
    end

    // Transmitter (busy 20 cycles per byte) and core (result 5 cycles after start) responders.
    int          busy_cnt = 0, core_cnt = 0;
    bit          last_pending = 0;
    txb_t        tb_b;
    logic [15:0] next_res = 0;
    always @(negedge CLK) begin
        core_done = 0;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0 && last_pending) begin
                exp_done.push_back(cyc + 1);
                last_pending = 0;
            end
        end else if (tx_start) begin
            if (exp_tx.size() == 0) check("tx_start_unexpected", tx_start, 0);
            else begin
                tb_b = exp_tx.pop_front();
                check("tx_data", tx_data, tb_b.data);
                if (tb_b.cyc >= 0) check("tx_start_cycle", cyc, tb_b.cyc);
                last_pending = tb_b.last;
            end
            busy_cnt = TX_BUSY_CYCLES;
        end
        tx_busy = busy_cnt != 0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_done   = 1;
                core_result = next_res;
                exp_tx.push_back('{next_res[15:8], tx_busy ? -1 : cyc + 1, 1'b0});
                exp_tx.push_back('{next_res[7:0], -1, 1'b1});
            end
        end else if (core_start) core_cnt = CORE_DELAY;
    end

    // Reference model: load_bus as a queue of bytes, first byte at index 0.
    logic [7:0] mbus[$];
    int         npart = 0, idle = 0;
    bit         pv = 0, keep_cur = 0;

    function automatic logic [31:0] pack();
        logic [31:0] v = 0;
        for (int i = 0; i < IN_BYTES; i++) v = {v[23:0], mbus[i]};
        return v;
    endfunction

    task automatic model_reset();
        mbus.delete();
        repeat (IN_BYTES) mbus.push_back(8'h00);
        pv = 0; npart = 0; idle = 0; keep_cur = 0;
    endtask

    // One cycle of receive-side stimulus while the DUT is loading.
    task automatic cyc_drive(logic v, logic e, logic [7:0] d);
        @(negedge CLK);
        rx_valid = v; en = e; rx_data = d;
        if (v && e) begin
            if (npart == 0) keep_cur = keep_prefix && pv;
            if (keep_cur) mbus.delete(PREFIX_BYTES);
            else mbus.delete(0);
            mbus.push_back(d);
            npart++;
            idle = 0;
            if (npart == (keep_cur ? IN_BYTES - PREFIX_BYTES : IN_BYTES)) begin
                exp_frame.push_back('{pack(), cyc + 1});
                npart = 0;
            end
        end else if (npart > 0) begin
            idle++;
            if (idle == TIMEOUT_CYCLES) begin
                exp_to.push_back(cyc + 1);
                npart = 0;
            end
        end
    endtask

    task automatic send(logic [7:0] d, int gap);
        repeat (gap) cyc_drive(0, 1, 0);
        cyc_drive(1, 1, d);
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 400) begin
            cyc_drive(0, 1, 0);
            n++;
        end
        checks++;
        if (done_cnt == start) begin
            errors++;
            $display("FAIL wait_done: no done pulse within 400 cycles (cycle %0d)", cyc);
        end
        cyc_drive(0, 1, 0);
        check("busy_after_done", busy, 0);
        pv = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] bus_before;
    int          n, nb;
    initial begin
        model_reset();
        repeat (3) @(negedge CLK);
        check("reset_outputs", {load_bus, core_start, tx_start, tx_data, busy, done, timeout_err, rx_drop}, 0);
        RSTn = 1;

        // Basic frame
        keep_prefix = 0; next_res = 16'hA5C3;
        foreach (mbus[i]) ;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        wait_done();

        // Prefix retention plus a byte dropped while waiting on the core
        keep_prefix = 1; next_res = 16'h3C96;
        send(8'h55, 1); send(8'h66, 2);
        cyc_drive(0, 1, 0);
        @(negedge CLK);
        rx_valid = 1; en = 1; rx_data = 8'hEE;
        exp_drop.push_back(cyc + 1);
        bus_before = load_bus;
        wait_done();
        check("load_bus_after_drop", load_bus, bus_before);

        // Timeout of a partial frame, then a full frame
        keep_prefix = 0; next_res = 16'h1234;
        send(8'hAA, 0); send(8'hBB, 0);
        repeat (TIMEOUT_CYCLES) cyc_drive(0, 1, 0);
        send(8'h01, 3); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        wait_done();

        // Byte arriving in the expiry cycle, plus disabled strobes
        next_res = 16'hBEEF;
        send(8'h10, 0);
        cyc_drive(1, 0, 8'hFF);
        send(8'h20, TIMEOUT_CYCLES - 2);
        cyc_drive(1, 0, 8'h77);
        send(8'h30, 0); send(8'h40, 1);
        wait_done();

        // Reset during TX_ACK of the first result byte
        next_res = 16'h5A3C;
        for (int i = 0; i < IN_BYTES; i++) send(8'($urandom), 0);
        n = 0;
        do begin
            cyc_drive(0, 1, 0);
            n++;
        end while (!tx_start && n < 100);
        check("tx_start_before_reset", tx_start, 1);
        RSTn = 0;
        @(negedge CLK);
        check("reset_mid_tx_outputs", {load_bus, core_start, tx_start, tx_data, busy, done, timeout_err, rx_drop}, 0);
        RSTn = 1;
        exp_tx.delete();
        last_pending = 0;
        model_reset();
        repeat (25) cyc_drive(0, 1, 0);
        keep_prefix = 1; next_res = 16'hC001;
        for (int i = 0; i < IN_BYTES; i++) send(8'($urandom), 0);
        wait_done();

        // Randomised frames
        for (int f = 0; f < 20; f++) begin
            keep_prefix = 1'($urandom_range(0, 1));
            next_res = 16'($urandom);
            nb = (keep_prefix && pv) ? IN_BYTES - PREFIX_BYTES : IN_BYTES;
            if ($urandom_range(0, 4) == 0) begin
                send(8'($urandom), 0);
                repeat (TIMEOUT_CYCLES + $urandom_range(0, 5)) cyc_drive(0, 1, 0);
            end
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 3) == 0) cyc_drive(1, 0, 8'($urandom));
                send(8'($urandom), $urandom_range(0, 3));
            end
            wait_done();
        end

        repeat (5) cyc_drive(0, 1, 0);
        check("frames_left", exp_frame.size(), 0);
        check("tx_left", exp_tx.size(), 0);
        check("done_left", exp_done.size(), 0);
        check("timeout_left", exp_to.size(), 0);
        check("drop_left", exp_drop.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
